// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, byte width and a counter-width helper.
package uart_pkg;

  localparam int NB_BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Number of bits needed to hold the values 0..value-1 (at least 1).
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          w;
    w = 0;
    if (value > 32'd1) begin
      v = value - 32'd1;
    end else begin
      v = 32'd0;
    end
    for (int i = 0; i < 32; i++) begin
      if (v > 32'd0) begin
        w = w + 1;
        v = v >> 1;
      end else begin
        w = w;
      end
    end
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int                CNT_W   = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: held at zero while cleared, wraps at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/tx_baudrate.sv
// UART transmitter: one 16-bit word per handshake, sent as two 8N1 (or 8N2) frames, low byte first.
module tx_baudrate
  import uart_pkg::*;
#(
  parameter int F_CLOCK = 5000000,
  parameter int BAUD    = 9600,
  parameter int NB_DATA = 16,
  parameter int NB_STOP = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CLKS_PER_BIT = F_CLOCK / BAUD;

  if (CLKS_PER_BIT < 2 || (NB_STOP != 1 && NB_STOP != 2) || NB_DATA != 2 * NB_BYTE) begin : g_param_check
    $fatal(1, "tx_baudrate: illegal parameter set");
  end

  uart_state_e        state_d, state_q;
  logic [NB_DATA-1:0] shreg_d, shreg_q;
  logic [2:0]         bit_idx_d, bit_idx_q;
  logic               byte_idx_d, byte_idx_q;
  logic               tx_d, tx_q;
  logic               ready_d, ready_q;
  logic               done_d, done_q;
  logic               tick_s;
  logic               clear_s;

  // The bit counter sits at zero while idle, so the accept edge starts a full bit period.
  assign clear_s = (state_q == ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (clear_s),
    .o_tick  (tick_s)
  );

  // Frame sequencing: next state, shifter, indices and the registered line/handshake values.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          shreg_d    = i_data;
          state_d    = ST_START;
          bit_idx_d  = 3'd0;
          byte_idx_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[NB_DATA-1:1]};
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[NB_DATA-1:1]};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (bit_idx_q == 3'(NB_STOP - 1)) begin
            bit_idx_d = 3'd0;
            if (byte_idx_q == 1'b0) begin
              // Second frame follows immediately with no idle gap.
              state_d    = ST_START;
              byte_idx_d = 1'b1;
              tx_d       = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = ~ready_q;
  assign o_done  = done_q;

endmodule
